alu4_rr_arbiter: RTL and testbench
==================================

Name: alu4_rr_arbiter

Overview:
Shares one registered W-bit arithmetic/logic stage between two requesters, each using a valid/ready handshake. A round-robin arbiter selects one operand pair per cycle. The selected pair is computed and registered, then returned on a single result channel tagged with the requester id. The block sits between operand-producing sequencers and the small arithmetic datapath, so that no requester needs its own adder.

Parameters:
W, 4, operand and result width in bits.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 presents an operation
req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
req0_a  in  W  requester 0 operand a
req0_b  in  W  requester 0 operand b
req0_op  in  2  requester 0 opcode
req1_valid  in  1  requester 1 presents an operation
req1_ready  out  1  requester 1 accept
req1_a  in  W  requester 1 operand a
req1_b  in  W  requester 1 operand b
req1_op  in  2  requester 1 opcode
res_valid  out  1  result register holds an unconsumed result
res_ready  in  1  consumer takes the result
res_data  out  W  result value
res_carry  out  1  carry (ADD) / borrow (SUB); 0 for logic ops
res_id  out  1  requester that issued the result

Behaviour:
- Reset (async, active-high): res_valid=0, res_data=0, res_carry=0, res_id=0, last_grant=1, so requester 0 wins the first tie. Any in-flight result is discarded.
- Opcodes:
  - 00 ADD: {carry,data} = a+b, computed at W+1 bits.
  - 01 SUB: data = a-b mod 2^W; carry = 1 when a<b (unsigned borrow).
  - 10 AND.
  - 11 XOR.
- Operands are unsigned bit vectors; wrap-around is mod 2^W with no saturation.
- Slot free: free = !res_valid || res_ready, combinational. It never depends on any reqN_valid.
- Grant, combinational, only when free:
  - One requester valid: that requester is granted.
  - Both valid: grant goes to !last_grant.
  - Neither valid: no grant.
  - reqN_ready = free && grant==N. A requester's ready is high only when it is granted.
- Accept, on the clock edge where reqN_valid && reqN_ready:
  - result fields load from the selected operands;
  - res_id=N, res_valid=1, last_grant=N.
  - Latency is exactly 1 cycle from accept edge to res_valid.
- Consume without new accept: res_valid && res_ready and no accept → res_valid=0. Data fields hold their last value.
- Simultaneous consume and accept in the same cycle: the new result replaces the old one and res_valid stays 1. Throughput is 1 operation per cycle under continuous res_ready.
- Backpressure: res_valid && !res_ready → both readies are 0 and all result outputs are held stable.
- Request inputs may change freely while not accepted. Inputs are sampled only on the accept edge.
- The FSM is implicit: EMPTY (res_valid=0) and FULL (res_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on consume without accept.
  - FULL→FULL on consume with accept, or on stall.
- last_grant changes only on accept.

Decomposition:
- Shared package alu4_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11;
  - default width constant 4.
- Sub-module alu4_core: purely combinational (a, b, op) → (data, carry), parameterised by W.
- The top level holds the arbiter, the handshake and the result register.

Test Plan:
- After reset, req0 ADD a=4'h3 b=4'h1, res_ready=1 → next cycle res_valid=1, res_data=4'h4, res_carry=0, res_id=0.
- req0 ADD a=4'hE b=4'h1 → res_data=4'hF, carry=0. Then ADD a=4'hF b=4'h1 → res_data=4'h0, carry=1.
- req1 SUB a=4'h1 b=4'h3 → res_data=4'hE, res_carry=1, res_id=1. AND 4'hC,4'hA → 4'h8. XOR 4'hC,4'hA → 4'h6.
- Both requesters valid for 4 consecutive cycles with res_ready=1 → grants alternate 0,1,0,1. Each res_id matches, one result per cycle.
- res_ready=0 with a result pending → both readies 0 and res_data held for 5 cycles. Raising res_ready together with req0_valid → consume and accept on the same edge, and res_valid stays 1.
- Assert reset asynchronously mid-clock while res_valid=1 → res_valid=0 immediately, with no clock edge. After release, a tie is granted to req0.

Source files
------------

// File: rtl/alu4_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode encodings,
// the default datapath width and the result-slot state type.
package alu4_pkg;

    localparam int W_DEF = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Result slot: EMPTY holds nothing to deliver, FULL holds an unconsumed result.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/alu4_rr_arbiter_if.sv
// Request/result bundle for alu4_rr_arbiter.
//   req0_*/req1_* : operand channels (valid/ready), a, b, 2-bit opcode
//   res_*         : result channel (valid/ready), data, carry/borrow, requester id
// slave  : the arbiter side.  master : the requesters + result consumer side.
interface alu4_rr_arbiter_if #(parameter int W = 4);

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [1:0]   req0_op;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [1:0]   req1_op;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_carry;
    logic         res_id;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output res_valid, res_data, res_carry, res_id,
        input  res_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  res_valid, res_data, res_carry, res_id,
        output res_ready
    );

endinterface

// File: rtl/alu4_core.sv
// Combinational W-bit ALU.
//   a_i, b_i  : unsigned operands
//   op_i      : ADD / SUB / AND / XOR
//   data_o    : result mod 2^W
//   carry_o   : carry-out for ADD, borrow (a<b) for SUB, 0 for logic ops
module alu4_core
    import alu4_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [1:0]   op_i,
    output logic [W-1:0] data_o,
    output logic         carry_o
);

    logic [W:0] sum;
    logic [W:0] diff;

    // One extra bit: MSB of the sum is the carry, MSB of the difference is
    // the unsigned borrow.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        data_o  = '0;
        carry_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                data_o  = sum[W-1:0];
                carry_o = sum[W];
            end
            OP_SUB: begin
                data_o  = diff[W-1:0];
                carry_o = diff[W];
            end
            OP_AND:  data_o = a_i & b_i;
            default: data_o = a_i ^ b_i;
        endcase
    end

endmodule

// File: rtl/alu4_rr_arbiter.sv
// Two requesters share one registered ALU stage through a round-robin arbiter.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : alu4_rr_arbiter_if.slave (two operand channels + one result channel)
// A grant is issued only when the result slot is free (empty or being
// consumed this cycle); the granted operands are computed and registered,
// giving one-cycle latency and full throughput under continuous res_ready.
module alu4_rr_arbiter
    import alu4_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    alu4_rr_arbiter_if.slave   bus
);

    localparam int NUM_REQ = 2;

    logic [NUM_REQ-1:0]        vld;
    logic [NUM_REQ-1:0][W-1:0] opa;
    logic [NUM_REQ-1:0][W-1:0] opb;
    logic [NUM_REQ-1:0][1:0]   opc;

    assign vld = {bus.req1_valid, bus.req0_valid};
    assign opa = {bus.req1_a,     bus.req0_a};
    assign opb = {bus.req1_b,     bus.req0_b};
    assign opc = {bus.req1_op,    bus.req0_op};

    slot_e        state_q;
    logic [W-1:0] data_q;
    logic         carry_q;
    logic         id_q;
    logic         last_q;

    logic         free;
    logic         gnt_vld;
    logic         gnt_id;
    logic [W-1:0] alu_data_d;
    logic         alu_carry_d;

    // Slot availability deliberately ignores the request valids so that
    // ready never combinationally depends on valid.
    assign free = (state_q == S_EMPTY) || bus.res_ready;

    // On a tie the requester that did not win last time goes first;
    // otherwise the single valid requester wins.
    always_comb begin
        gnt_vld = free && (|vld);
        gnt_id  = (&vld) ? ~last_q : vld[1];
    end

    assign bus.req0_ready = gnt_vld && !gnt_id;
    assign bus.req1_ready = gnt_vld &&  gnt_id;

    alu4_core #(.W(W)) u_core (
        .a_i     (opa[gnt_id]),
        .b_i     (opb[gnt_id]),
        .op_i    (opc[gnt_id]),
        .data_o  (alu_data_d),
        .carry_o (alu_carry_d)
    );

    // gnt_vld already implies the granted requester is valid, so it is the
    // accept strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (gnt_vld) begin
                        state_q <= S_FULL;
                        data_q  <= alu_data_d;
                        carry_q <= alu_carry_d;
                        id_q    <= gnt_id;
                        last_q  <= gnt_id;
                    end
                end
                default: begin
                    if (gnt_vld) begin
                        data_q  <= alu_data_d;
                        carry_q <= alu_carry_d;
                        id_q    <= gnt_id;
                        last_q  <= gnt_id;
                    end else if (bus.res_ready) begin
                        state_q <= S_EMPTY;
                    end
                end
            endcase
        end
    end

    assign bus.res_valid = (state_q == S_FULL);
    assign bus.res_data  = data_q;
    assign bus.res_carry = carry_q;
    assign bus.res_id    = id_q;

endmodule

// File: tb/tb_alu4_rr_arbiter.sv
module tb_alu4_rr_arbiter;
    import alu4_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu4_rr_arbiter_if #(.W(4)) bus ();

    alu4_rr_arbiter #(.W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic       m_valid;
    logic [3:0] m_data;
    logic       m_carry;
    logic       m_id;
    logic       m_last;
    logic       e_rdy0;
    logic       e_rdy1;

    function automatic logic [4:0] golden(logic [3:0] a, logic [3:0] b, logic [1:0] op);
        int   ai;
        int   bi;
        int   r;
        logic c;
        ai = int'(a);
        bi = int'(b);
        c  = 1'b0;
        case (op)
            OP_ADD: begin r = ai + bi; c = (r > 15); r = r % 16; end
            OP_SUB: begin c = (ai < bi); r = (ai - bi + 16) % 16; end
            OP_AND: r = ai & bi;
            default: r = ai ^ bi;
        endcase
        return {c, r[3:0]};
    endfunction

    // Who should be accepted right now, from the rules: slot must be free;
    // a single valid requester wins, a tie goes to whoever did not win last.
    always_comb begin
        e_rdy0 = 1'b0;
        e_rdy1 = 1'b0;
        if (!m_valid || bus.res_ready) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (m_last) e_rdy0 = 1'b1;
                else        e_rdy1 = 1'b1;
            end else begin
                e_rdy0 = bus.req0_valid;
                e_rdy1 = bus.req1_valid;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= 4'h0;
            m_carry <= 1'b0;
            m_id    <= 1'b0;
            m_last  <= 1'b1;
        end else if (e_rdy0) begin
            {m_carry, m_data} <= golden(bus.req0_a, bus.req0_b, bus.req0_op);
            m_valid <= 1'b1;
            m_id    <= 1'b0;
            m_last  <= 1'b0;
        end else if (e_rdy1) begin
            {m_carry, m_data} <= golden(bus.req1_a, bus.req1_b, bus.req1_op);
            m_valid <= 1'b1;
            m_id    <= 1'b1;
            m_last  <= 1'b1;
        end else if (m_valid && bus.res_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle compare against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("cyc_rdy0", {7'd0, bus.req0_ready}, {7'd0, e_rdy0});
                chk("cyc_rdy1", {7'd0, bus.req1_ready}, {7'd0, e_rdy1});
                chk("cyc_valid", {7'd0, bus.res_valid}, {7'd0, m_valid});
                if (m_valid) begin
                    chk("cyc_data",  {4'd0, bus.res_data},  {4'd0, m_data});
                    chk("cyc_carry", {7'd0, bus.res_carry}, {7'd0, m_carry});
                    chk("cyc_id",    {7'd0, bus.res_id},    {7'd0, m_id});
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
            bus.req0_valid = 1'b0;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
            bus.req1_valid = 1'b0;
        end
        step();
    endtask

    task automatic lit(input string name, input logic [3:0] d, input logic c, input logic id);
        chk({name, "_valid"}, {7'd0, bus.res_valid}, 8'd1);
        chk({name, "_data"},  {4'd0, bus.res_data},  {4'd0, d});
        chk({name, "_carry"}, {7'd0, bus.res_carry}, {7'd0, c});
        chk({name, "_id"},    {7'd0, bus.res_id},    {7'd0, id});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.res_ready = 1'b1;
        #1 reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("rst_data",  {4'd0, bus.res_data},  8'd0);
        chk("rst_carry", {7'd0, bus.res_carry}, 8'd0);
        chk("rst_id",    {7'd0, bus.res_id},    8'd0);
        chk("rst_rdy",   {6'd0, bus.req1_ready, bus.req0_ready}, 8'd0);

        issue(1'b0, 4'h3, 4'h1, OP_ADD); lit("add31", 4'h4, 1'b0, 1'b0);
        issue(1'b0, 4'hE, 4'h1, OP_ADD); lit("addE1", 4'hF, 1'b0, 1'b0);
        issue(1'b0, 4'hF, 4'h1, OP_ADD); lit("addF1", 4'h0, 1'b1, 1'b0);
        issue(1'b1, 4'h1, 4'h3, OP_SUB); lit("sub13", 4'hE, 1'b1, 1'b1);
        issue(1'b1, 4'hC, 4'hA, OP_AND); lit("andCA", 4'h8, 1'b0, 1'b1);
        issue(1'b1, 4'hC, 4'hA, OP_XOR); lit("xorCA", 4'h6, 1'b0, 1'b1);

        // Tie for four cycles: last winner was req1, so 0,1,0,1.
        bus.req0_valid = 1'b1; bus.req0_a = 4'h1; bus.req0_b = 4'h1; bus.req0_op = OP_ADD;
        bus.req1_valid = 1'b1; bus.req1_a = 4'h2; bus.req1_b = 4'h2; bus.req1_op = OP_ADD;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i % 2 == 0) lit("rr_even", 4'h2, 1'b0, 1'b0);
            else            lit("rr_odd",  4'h4, 1'b0, 1'b1);
        end

        // Backpressure: result 4/id1 pending, both requesters waiting.
        bus.res_ready = 1'b0;
        bus.req0_a = 4'h5; bus.req0_b = 4'h5;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rdy", {6'd0, bus.req1_ready, bus.req0_ready}, 8'd0);
            lit("bp_hold", 4'h4, 1'b0, 1'b1);
            step();
        end
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b1;
        #1;
        chk("swap_rdy0", {7'd0, bus.req0_ready}, 8'd1);
        step();
        lit("swap", 4'hA, 1'b0, 1'b0);

        // Consume without accept: valid drops, data holds.
        bus.req0_valid = 1'b0;
        step();
        chk("drain_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("drain_data",  {4'd0, bus.res_data},  8'h0A);

        // Asynchronous reset while a result is pending.
        bus.res_ready = 1'b0;
        issue(1'b1, 4'hF, 4'h0, OP_XOR); lit("pre_rst", 4'hF, 1'b0, 1'b1);
        bus.req1_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("arst_data",  {4'd0, bus.res_data},  8'd0);
        chk("arst_id",    {7'd0, bus.res_id},    8'd0);
        step();
        reset = 1'b0;
        bus.res_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 4'h3; bus.req0_b = 4'h5; bus.req0_op = OP_XOR;
        bus.req1_valid = 1'b1; bus.req1_a = 4'h3; bus.req1_b = 4'h5; bus.req1_op = OP_AND;
        #1;
        chk("post_rdy", {6'd0, bus.req1_ready, bus.req0_ready}, 8'd1);
        step();
        lit("post_tie", 4'h6, 1'b0, 1'b0);

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
